// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin front end for one shared combinational ALU.
// Two requesters compete. The winner's op/a/b are latched and driven to the
// ALU for one EXEC cycle. The ALU result is registered and returned on the
// winner's response channel, which uses valid/ready handshaking.
// Optional feature: define ALU_ARB_OPCHECK_EN to flag opcodes > 6 as
// illegal. Such a request runs with alu_op=0 and returns data=0, err=1.
module alu_arbiter #(
    parameter int WIDTH = 32,
    parameter int OPW   = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [OPW-1:0]   req_op_0,
    input  logic [OPW-1:0]   req_op_1,
    input  logic [WIDTH-1:0] req_a_0,
    input  logic [WIDTH-1:0] req_a_1,
    input  logic [WIDTH-1:0] req_b_0,
    input  logic [WIDTH-1:0] req_b_1,
    output logic [1:0]       resp_valid,
    input  logic [1:0]       resp_ready,
    output logic [WIDTH-1:0] resp_data,
    output logic             resp_err,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [OPW-1:0]   alu_op,
    input  logic [WIDTH-1:0] alu_out,
    output logic             busy
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t           r_state;
    logic             r_owner;
    logic             r_last_grant;
    logic [OPW-1:0]   r_alu_op;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_result;
    logic [1:0]       r_resp_valid;

    logic [1:0]       w_grant;
    logic             w_hs;
    logic             w_sel;
    logic [OPW-1:0]   w_sel_op;
    logic [WIDTH-1:0] w_sel_a;
    logic [WIDTH-1:0] w_sel_b;
    logic             w_illegal;
    logic             w_err;

`ifdef ALU_ARB_OPCHECK_EN
    logic r_err;
    assign w_illegal = (w_sel_op > OPW'(6));
    assign w_err     = r_err;
`else
    assign w_illegal = 1'b0;
    assign w_err     = 1'b0;
`endif

    // Round-robin grant, offered only in IDLE; on a tie the requester that
    // did not win last time goes first. Gated by rst_n so every output
    // reads 0 while reset is held.
    always_comb begin
        w_grant = 2'b00;
        if (r_state == IDLE && rst_n) begin
            case (req_valid)
                2'b01:   w_grant = 2'b01;
                2'b10:   w_grant = 2'b10;
                2'b11:   w_grant = r_last_grant ? 2'b01 : 2'b10;
                default: w_grant = 2'b00;
            endcase
        end
    end

    // A grant is only ever given to a valid requester, so any grant is a
    // completed handshake.
    assign w_hs     = |w_grant;
    assign w_sel    = w_grant[1];
    assign w_sel_op = w_sel ? req_op_1 : req_op_0;
    assign w_sel_a  = w_sel ? req_a_1  : req_a_0;
    assign w_sel_b  = w_sel ? req_b_1  : req_b_0;

    assign req_ready  = w_grant;
    assign resp_valid = r_resp_valid;
    assign resp_data  = r_result;
    assign resp_err   = w_err;
    assign alu_a      = r_a;
    assign alu_b      = r_b;
    assign alu_op     = r_alu_op;
    assign busy       = (r_state != IDLE);

    // Control FSM: latch the winner, run the ALU for one cycle, then hold
    // the response until its owner consumes it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_owner      <= 1'b0;
            r_last_grant <= 1'b1;
            r_alu_op     <= '0;
            r_a          <= '0;
            r_b          <= '0;
            r_result     <= '0;
            r_resp_valid <= 2'b00;
`ifdef ALU_ARB_OPCHECK_EN
            r_err        <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_hs) begin
                        r_a          <= w_sel_a;
                        r_b          <= w_sel_b;
                        r_owner      <= w_sel;
                        r_last_grant <= w_sel;
                        // alu_op is nonzero only during EXEC; an illegal op
                        // runs as op 0.
                        r_alu_op     <= w_illegal ? '0 : w_sel_op;
`ifdef ALU_ARB_OPCHECK_EN
                        r_err        <= w_illegal;
`endif
                        r_state      <= EXEC;
                    end
                end
                EXEC: begin
                    r_result     <= w_err ? '0 : alu_out;
                    r_alu_op     <= '0;
                    r_resp_valid <= r_owner ? 2'b10 : 2'b01;
                    r_state      <= RESP;
                end
                RESP: begin
                    // Only the owner's ready bit is honoured. IDLE is
                    // re-entered next cycle, so a waiting request is
                    // accepted one cycle after the drain.
                    if (resp_ready[r_owner]) begin
                        r_resp_valid <= 2'b00;
                        r_state      <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter. It includes a behavioural model of the
// shared ALU. Ops 0..6 are modelled and anything else returns 32'hDEADBEEF.
module tb_alu_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  req_valid, req_ready, resp_valid, resp_ready;
    logic [4:0]  req_op_0, req_op_1, alu_op;
    logic [31:0] req_a_0, req_a_1, req_b_0, req_b_1;
    logic [31:0] resp_data, alu_a, alu_b, alu_out;
    logic        resp_err, busy;

    int pass_cnt = 0;
    int chk_cnt  = 0;

    alu_arbiter #(.WIDTH(32), .OPW(5)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op_0(req_op_0), .req_op_1(req_op_1),
        .req_a_0(req_a_0), .req_a_1(req_a_1),
        .req_b_0(req_b_0), .req_b_1(req_b_1),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_data(resp_data), .resp_err(resp_err),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_out(alu_out), .busy(busy)
    );

    always #5 clk = ~clk;

    // Shared ALU model
    always_comb begin
        case (alu_op)
            5'd0:    alu_out = 32'h0;
            5'd1:    alu_out = alu_a + alu_b;
            5'd2:    alu_out = alu_a - alu_b;
            5'd3:    alu_out = alu_a & alu_b;
            5'd4:    alu_out = alu_a | alu_b;
            5'd5:    alu_out = alu_a ^ alu_b;
            5'd6:    alu_out = ~(alu_a | alu_b);
            default: alu_out = 32'hDEADBEEF;
        endcase
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    // Driver only: issue one request and drain its response, with bounded waits.
    task automatic run_op(input int idx, input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] d, output logic e, output bit ok);
        bit got;
        ok = 1'b0; got = 1'b0; d = '0; e = 1'b0;
        if (idx == 0) begin req_op_0 = op; req_a_0 = a; req_b_0 = b; end
        else          begin req_op_1 = op; req_a_1 = a; req_b_1 = b; end
        req_valid[idx] = 1'b1;
        #1;
        for (int k = 0; k < 10; k++) begin
            if (req_ready[idx]) begin got = 1'b1; break; end
            tick();
        end
        if (got) begin
            tick();
            req_valid[idx] = 1'b0;
            for (int k = 0; k < 10; k++) begin
                if (resp_valid[idx]) begin d = resp_data; e = resp_err; ok = 1'b1; break; end
                tick();
            end
        end
        req_valid[idx] = 1'b0;
        resp_ready[idx] = 1'b1;
        tick();
        resp_ready[idx] = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req_valid = 2'b00; resp_ready = 2'b00;
        req_op_0 = '0; req_op_1 = '0; req_a_0 = '0; req_a_1 = '0; req_b_0 = '0; req_b_1 = '0;
        #3;
        chk_cnt++; if (req_ready !== 2'b00) $display("FAIL reset_req_ready: got %b want 00", req_ready); else pass_cnt++;
        chk_cnt++; if (resp_valid !== 2'b00) $display("FAIL reset_resp_valid: got %b want 00", resp_valid); else pass_cnt++;
        chk_cnt++; if (resp_data !== 32'h0 || resp_err !== 1'b0) $display("FAIL reset_resp: got %h/%b want 0/0", resp_data, resp_err); else pass_cnt++;
        chk_cnt++; if (alu_a !== 32'h0 || alu_b !== 32'h0 || alu_op !== 5'h0) $display("FAIL reset_alu: got %h/%h/%h want 0", alu_a, alu_b, alu_op); else pass_cnt++;
        chk_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else pass_cnt++;
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        req_op_0 = 5'd1; req_a_0 = 32'd5; req_b_0 = 32'd7;
        req_valid = 2'b01; resp_ready = 2'b01;
        #1;
        chk_cnt++; if (req_ready !== 2'b01 || busy !== 1'b0) $display("FAIL basic_c0: got ready=%b busy=%b want 01/0", req_ready, busy); else pass_cnt++;
        tick();
        req_valid = 2'b00;
        chk_cnt++; if (alu_op !== 5'd1 || alu_a !== 32'd5 || alu_b !== 32'd7) $display("FAIL basic_exec_alu: got %h/%h/%h want 1/5/7", alu_op, alu_a, alu_b); else pass_cnt++;
        chk_cnt++; if (busy !== 1'b1 || resp_valid !== 2'b00) $display("FAIL basic_c1: got busy=%b rv=%b want 1/00", busy, resp_valid); else pass_cnt++;
        tick();
        chk_cnt++; if (resp_valid !== 2'b01 || resp_data !== 32'd12) $display("FAIL basic_resp: got %b/%h want 01/0000000c", resp_valid, resp_data); else pass_cnt++;
        chk_cnt++; if (busy !== 1'b1 || alu_op !== 5'd0) $display("FAIL basic_c2: got busy=%b op=%h want 1/0", busy, alu_op); else pass_cnt++;
        tick();
        resp_ready = 2'b00;
        chk_cnt++; if (resp_valid !== 2'b00 || busy !== 1'b0) $display("FAIL basic_c3: got rv=%b busy=%b want 00/0", resp_valid, busy); else pass_cnt++;
    endtask

    task automatic test_tie();
        do_reset();
        req_op_0 = 5'd2; req_a_0 = 32'd3;  req_b_0 = 32'd5;
        req_op_1 = 5'd2; req_a_1 = 32'd10; req_b_1 = 32'd4;
        req_valid = 2'b11; resp_ready = 2'b00;
        #1;
        chk_cnt++; if (req_ready !== 2'b01) $display("FAIL tie_first: got %b want 01", req_ready); else pass_cnt++;
        tick();
        req_valid = 2'b10;
        #1;
        chk_cnt++; if (req_ready !== 2'b00) $display("FAIL tie_exec_ready: got %b want 00", req_ready); else pass_cnt++;
        tick();
        chk_cnt++; if (resp_valid !== 2'b01 || resp_data !== 32'hFFFFFFFE) $display("FAIL tie_r0_resp: got %b/%h want 01/fffffffe", resp_valid, resp_data); else pass_cnt++;
        resp_ready = 2'b01;
        #1;
        chk_cnt++; if (req_ready !== 2'b00) $display("FAIL tie_drain_ready: got %b want 00", req_ready); else pass_cnt++;
        tick();
        resp_ready = 2'b00;
        #1;
        chk_cnt++; if (req_ready !== 2'b10 || resp_valid !== 2'b00) $display("FAIL tie_r1_grant: got ready=%b rv=%b want 10/00", req_ready, resp_valid); else pass_cnt++;
        tick();
        req_valid = 2'b00;
        tick();
        chk_cnt++; if (resp_valid !== 2'b10 || resp_data !== 32'd6) $display("FAIL tie_r1_resp: got %b/%h want 10/00000006", resp_valid, resp_data); else pass_cnt++;
        resp_ready = 2'b10;
        tick();
        resp_ready = 2'b00;
        req_valid = 2'b11;
        #1;
        chk_cnt++; if (req_ready !== 2'b01) $display("FAIL tie_third: got %b want 01", req_ready); else pass_cnt++;
        // Both withdraw before the edge, so no grant is taken.
        req_valid = 2'b00;
        tick();
        chk_cnt++; if (busy !== 1'b0) $display("FAIL tie_withdraw_busy: got %b want 0", busy); else pass_cnt++;
    endtask

    task automatic test_backpressure();
        req_op_1 = 5'd5; req_a_1 = 32'hF0F0F0F0; req_b_1 = 32'hFFFF0000;
        req_valid = 2'b10; resp_ready = 2'b00;
        #1;
        chk_cnt++; if (req_ready !== 2'b10) $display("FAIL bp_grant: got %b want 10", req_ready); else pass_cnt++;
        tick();
        req_op_0 = 5'd1; req_a_0 = 32'd1; req_b_0 = 32'd1;
        req_valid = 2'b01;
        tick();
        for (int i = 0; i < 4; i++) begin
            resp_ready = 2'b01;
            #1;
            chk_cnt++;
            if (resp_valid !== 2'b10 || resp_data !== 32'h0F0FF0F0 || req_ready !== 2'b00)
                $display("FAIL bp_hold%0d: got rv=%b d=%h rdy=%b want 10/0f0ff0f0/00", i, resp_valid, resp_data, req_ready);
            else pass_cnt++;
            tick();
        end
        resp_ready = 2'b10;
        #1;
        chk_cnt++; if (req_ready !== 2'b00) $display("FAIL bp_drain_ready: got %b want 00", req_ready); else pass_cnt++;
        tick();
        resp_ready = 2'b00;
        #1;
        chk_cnt++; if (req_ready !== 2'b01 || resp_valid !== 2'b00) $display("FAIL bp_next_grant: got rdy=%b rv=%b want 01/00", req_ready, resp_valid); else pass_cnt++;
        tick();
        req_valid = 2'b00;
        tick();
        chk_cnt++; if (resp_valid !== 2'b01 || resp_data !== 32'd2) $display("FAIL bp_r0_resp: got %b/%h want 01/00000002", resp_valid, resp_data); else pass_cnt++;
        resp_ready = 2'b01;
        tick();
        resp_ready = 2'b00;
    endtask

    task automatic test_ops();
        logic [31:0] d; logic e; bit ok;
        run_op(0, 5'd6, 32'h0, 32'h0, d, e, ok);
        chk_cnt++; if (!ok || d !== 32'hFFFFFFFF || e !== 1'b0) $display("FAIL op_nor: got ok=%0d %h/%b want ffffffff/0", ok, d, e); else pass_cnt++;
        run_op(1, 5'd0, 32'h5, 32'h3, d, e, ok);
        chk_cnt++; if (!ok || d !== 32'h0) $display("FAIL op_zero: got ok=%0d %h want 00000000", ok, d); else pass_cnt++;
        run_op(0, 5'd1, 32'h7FFFFFFF, 32'h1, d, e, ok);
        chk_cnt++; if (!ok || d !== 32'h80000000) $display("FAIL op_add_wrap: got ok=%0d %h want 80000000", ok, d); else pass_cnt++;
        run_op(1, 5'd3, 32'hFF00FF00, 32'h0FF00FF0, d, e, ok);
        chk_cnt++; if (!ok || d !== 32'h0F000F00) $display("FAIL op_and: got ok=%0d %h want 0f000f00", ok, d); else pass_cnt++;
        run_op(0, 5'd4, 32'hFF000000, 32'h000000FF, d, e, ok);
        chk_cnt++; if (!ok || d !== 32'hFF0000FF) $display("FAIL op_or: got ok=%0d %h want ff0000ff", ok, d); else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        bit seen;
        seen = 1'b0;
        req_op_0 = 5'd1; req_a_0 = 32'd1; req_b_0 = 32'd2;
        req_valid = 2'b01;
        #1;
        tick();
        req_valid = 2'b00;
        rst_n = 1'b0;
        #1;
        chk_cnt++; if (busy !== 1'b0 || alu_op !== 5'd0 || alu_a !== 32'h0 || alu_b !== 32'h0) $display("FAIL rstmid_outs: got busy=%b op=%h a=%h b=%h want 0", busy, alu_op, alu_a, alu_b); else pass_cnt++;
        chk_cnt++; if (resp_valid !== 2'b00 || resp_data !== 32'h0 || req_ready !== 2'b00) $display("FAIL rstmid_resp: got rv=%b d=%h rdy=%b want 0", resp_valid, resp_data, req_ready); else pass_cnt++;
        tick();
        rst_n = 1'b1;
        resp_ready = 2'b11;
        for (int i = 0; i < 6; i++) begin
            if (resp_valid !== 2'b00) seen = 1'b1;
            tick();
        end
        resp_ready = 2'b00;
        chk_cnt++; if (seen !== 1'b0) $display("FAIL rstmid_no_resp: got seen=%b want 0", seen); else pass_cnt++;
        req_valid = 2'b11;
        #1;
        chk_cnt++; if (req_ready !== 2'b01) $display("FAIL rstmid_tie: got %b want 01", req_ready); else pass_cnt++;
        req_valid = 2'b00;
        tick();
    endtask

    task automatic test_opcheck();
        logic [4:0]  exp_op;
        logic [31:0] exp_d;
        logic        exp_e;
`ifdef ALU_ARB_OPCHECK_EN
        exp_op = 5'd0; exp_d = 32'h0; exp_e = 1'b1;
`else
        exp_op = 5'd9; exp_d = 32'hDEADBEEF; exp_e = 1'b0;
`endif
        req_op_0 = 5'd9; req_a_0 = 32'd1; req_b_0 = 32'd2;
        req_valid = 2'b01; resp_ready = 2'b01;
        #1;
        tick();
        req_valid = 2'b00;
        chk_cnt++; if (alu_op !== exp_op) $display("FAIL opchk_alu_op: got %h want %h", alu_op, exp_op); else pass_cnt++;
        tick();
        chk_cnt++; if (resp_valid !== 2'b01 || resp_data !== exp_d || resp_err !== exp_e) $display("FAIL opchk_resp: got %b/%h/%b want 01/%h/%b", resp_valid, resp_data, resp_err, exp_d, exp_e); else pass_cnt++;
        tick();
        resp_ready = 2'b00;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_tie();
        test_backpressure();
        test_ops();
        test_reset_mid();
        test_opcheck();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares one combinational ALU (ops 0..6: zero, add, sub, and, or, xor, nor) between two requesters.
- Arbitrates round-robin, latches the winner's operands and drives the ALU for one cycle. Registers the result and returns it on the winner's response channel with valid/ready backpressure.
- Sits between the datapath issue logic (requesters) and the ALU instance.

Parameters:
- WIDTH, 32, operand/result width.
- OPW, 5, opcode width (matches the ALU op port).

Ports:
- Interface: one clock; reset is asynchronous and active-low.
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  2  request valid, bit i = requester i.
- req_ready  out  2  request accepted, one-hot or zero.
- req_op_0 / req_op_1  in  OPW  opcode per requester.
- req_a_0 / req_a_1  in  WIDTH  operand A per requester.
- req_b_0 / req_b_1  in  WIDTH  operand B per requester.
- resp_valid  out  2  result valid, bit i = requester i.
- resp_ready  in  2  result consumed, bit i = requester i.
- resp_data  out  WIDTH  result, shared bus, meaningful for the asserted resp_valid bit.
- resp_err  out  1  illegal-opcode flag, qualified by resp_valid.
- alu_a / alu_b  out  WIDTH  to ALU operands.
- alu_op  out  OPW  to ALU opcode.
- alu_out  in  WIDTH  from ALU result.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- FSM states: IDLE, EXEC, RESP. Reset state is IDLE.
- Reset values: all outputs 0; internal op/a/b/result/err registers 0; last_grant=1, so requester 0 wins the first tie.
- IDLE:
  - req_ready is combinational. With one valid, grant it. With both valid, grant the one != last_grant.
  - Handshake completes on the edge where req_valid[i] & req_ready[i]. On that edge: latch op/a/b, set owner=i, last_grant=i, go to EXEC.
  - req_ready=0 in all other states.
- EXEC (exactly 1 cycle):
  - alu_a/alu_b/alu_op driven from the latched registers.
  - alu_out captured into the result register at the end of the cycle; go to RESP.
  - Outside EXEC, alu_op=0 and alu_a/alu_b hold their latched values.
- RESP:
  - resp_valid[owner]=1; resp_data=result; resp_err=err.
  - Hold all of these stable until resp_ready[owner]=1, then go to IDLE on that edge.
  - resp_ready on the non-owner bit is ignored.
- Latency:
  - Handshake edge -> resp_valid high 2 cycles later.
  - Minimum issue interval is 3 cycles. The next request cannot be accepted in the same cycle the response is consumed; it is accepted in the following IDLE cycle.
- Arithmetic: purely what the ALU returns, WIDTH bits, two's-complement wrap, no carry/overflow output.
- Requester drops req_valid before the handshake: no effect, no grant recorded.
- Requester changes operands while not granted: allowed, and only the values at the handshake edge are used.
- Reset asserted mid-operation: immediately back to IDLE, all outputs 0, and the in-flight transaction is discarded with no response.
- Simultaneous resp_ready and a new req_valid: response completes, and the new request waits one cycle.

Optional Feature:
- Macro: ALU_ARB_OPCHECK_EN.
- Defined:
  - Opcodes > 6 are detected at the handshake and err is set.
  - EXEC is still one cycle, but alu_op=0 and the result is forced to 0. The response carries resp_data=0, resp_err=1.
- Undefined:
  - Every opcode is forwarded unchanged and the result is whatever alu_out returns.
  - resp_err is tied 0, and the err register is not synthesized.

Test Plan:
- Reset, then requester 0 sends op=1, a=5, b=7 with resp_ready=1: req_ready[0] high in cycle 0, alu_op=1 in cycle 1, resp_valid=2'b01 with resp_data=12 in cycle 2, busy high cycles 1-2.
- Both requesters valid at once, both op=2: r0 (a=3, b=5) and r1 (a=10, b=4): r0 served first with 0xFFFFFFFE. r1 accepted next IDLE with 6. A third tie then goes to r0.
- Backpressure: r1 op=5, a=0xF0F0F0F0, b=0xFFFF0000, resp_ready held 0 for 4 cycles: resp_valid[1] and resp_data=0x0F0FF0F0 stable throughout. New r0 request stays un-readied until the response drains.
- op=6, a=0, b=0 -> 0xFFFFFFFF. op=0 -> 0. op=1 with a=0x7FFFFFFF, b=1 -> 0x80000000.
- Assert rst_n low during EXEC: all outputs 0 asynchronously. No resp_valid after release. Next tie goes to r0.
- With ALU_ARB_OPCHECK_EN, op=9, a=1, b=2: alu_op=0 in EXEC, resp_data=0, resp_err=1. Without the macro: resp_err=0, resp_data=alu_out.
